// File: rtl/uart_pkg.sv
// Shared types and sizing helpers for the UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Counter width that never collapses to zero bits for a terminal value of 1.
  function automatic int cnt_w(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/uart_rx_bit_synchronizer.sv
// Two-flop synchronizer for a single asynchronous input bit.
module bit_synchronizer #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rstN,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling of start, data (LSB first) and stop bits.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] byte_out,
  output logic                  ready,
  output logic                  new_byte_indicate,
  output logic                  framing_err
);

  localparam int CW = cnt_w(CLKS_PER_BIT);
  localparam int BW = cnt_w(DATA_WIDTH);
  localparam logic [CW-1:0] HALF  = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BLAST = BW'(DATA_WIDTH - 1);

  logic rx_s;

  bit_synchronizer #(.RESET_VAL(1'b1)) u_sync (
    .clk  (clk),
    .rstN (rstN),
    .d    (rx),
    .q    (rx_s)
  );

  rx_state_t             state,     state_nxt;
  logic [CW-1:0]         clk_cnt,   clk_cnt_nxt;
  logic [BW-1:0]         bit_idx,   bit_idx_nxt;
  logic [DATA_WIDTH-1:0] shift_reg, shift_nxt;
  logic [DATA_WIDTH-1:0] byte_nxt;
  logic                  armed,     armed_nxt;
  logic                  fe_nxt,    pulse_nxt;

  always_comb begin
    state_nxt   = state;
    clk_cnt_nxt = clk_cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift_reg;
    byte_nxt    = byte_out;
    armed_nxt   = armed;
    fe_nxt      = framing_err;
    pulse_nxt   = 1'b0;
    case (state)
      RX_IDLE: begin
        // After a break, wait for the line to return high before re-arming.
        if (rx_s) armed_nxt = 1'b1;
        if (armed && !rx_s) begin
          state_nxt   = RX_START;
          clk_cnt_nxt = '0;
        end
      end
      RX_START: begin
        if (clk_cnt == HALF) begin
          if (!rx_s) begin
            pulse_nxt   = 1'b1;
            fe_nxt      = 1'b0;
            clk_cnt_nxt = '0;
            bit_idx_nxt = '0;
            state_nxt   = RX_DATA;
          end else begin
            state_nxt = RX_IDLE;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (clk_cnt == LAST) begin
          shift_nxt = shift_reg >> 1;
          shift_nxt[DATA_WIDTH-1] = rx_s;
          clk_cnt_nxt = '0;
          if (bit_idx == BLAST) state_nxt = RX_STOP;
          else bit_idx_nxt = bit_idx + 1'b1;
        end else begin
          clk_cnt_nxt = clk_cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (clk_cnt == LAST) begin
          byte_nxt  = shift_reg;
          fe_nxt    = ~rx_s;
          armed_nxt = rx_s;
          state_nxt = RX_IDLE;
        end else begin
          clk_cnt_nxt = clk_cnt + 1'b1;
        end
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state             <= RX_IDLE;
      clk_cnt           <= '0;
      bit_idx           <= '0;
      shift_reg         <= '0;
      byte_out          <= '0;
      armed             <= 1'b1;
      framing_err       <= 1'b0;
      new_byte_indicate <= 1'b0;
      ready             <= 1'b1;
    end else begin
      state             <= state_nxt;
      clk_cnt           <= clk_cnt_nxt;
      bit_idx           <= bit_idx_nxt;
      shift_reg         <= shift_nxt;
      byte_out          <= byte_nxt;
      armed             <= armed_nxt;
      framing_err       <= fe_nxt;
      new_byte_indicate <= pulse_nxt;
      ready             <= (state_nxt == RX_IDLE);
    end
  end

endmodule
